// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared defaults and word type for the fifo block
// Holds the default word width and depth plus the word typedef used by the
// fifo and by anything that talks to it.
package fifo_pkg;

  localparam int FIFO_WIDTH_DEF = 16;
  localparam int FIFO_DEPTH_DEF = 16;

  typedef logic [FIFO_WIDTH_DEF-1:0] fifo_word_t;

endpackage : fifo_pkg

// File: rtl/fifo.sv
// rtl/fifo.sv - single-clock circular-queue fifo with registered read data
// Ports:
//   clk    - rising-edge clock for all state
//   reset  - asynchronous active-low reset (clears pointers, count, d_out)
//   write  - push request, d_in sampled on the same edge
//   read   - pop request
//   d_in   - word to push
//   full   - occupancy == DEPTH
//   empty  - occupancy == 0
//   d_out  - word popped on the most recent accepted read (held otherwise)
module fifo
  import fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH_DEF,
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             write,
  input  logic             read,
  input  logic [WIDTH-1:0] d_in,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] d_out
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q,  count_d;
  logic [WIDTH-1:0] d_out_q,  d_out_d;

  logic push_ok;
  logic pop_ok;

  assign full  = (count_q == DEPTH_CNT);
  assign empty = (count_q == '0);
  assign d_out = d_out_q;

  // Acceptance uses pre-edge flags, so a simultaneous read on empty or write
  // on full degrades to a push-only or pop-only cycle respectively.
  assign push_ok = write & ~full;
  assign pop_ok  = read & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    d_out_d  = d_out_q;

    // DEPTH is a power of two, so the natural AW-bit overflow is the wrap.
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      d_out_d  = mem_q[rd_ptr_q];
    end

    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      d_out_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      d_out_q  <= d_out_d;
    end
  end

  // Storage is deliberately left out of reset; stale words are unreachable
  // because the pointers and count are cleared.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= d_in;
    end
  end

endmodule : fifo

// File: tb/tb_fifo.sv
// tb/tb_fifo.sv - randomized and directed self-checking bench for fifo
module tb_fifo;
  import fifo_pkg::*;

  localparam int DEPTH = FIFO_DEPTH_DEF;

  logic       clk;
  logic       reset;
  logic       write;
  logic       read;
  fifo_word_t d_in;
  logic       full;
  logic       empty;
  fifo_word_t d_out;

  fifo dut (
    .clk   (clk),
    .reset (reset),
    .write (write),
    .read  (read),
    .d_in  (d_in),
    .full  (full),
    .empty (empty),
    .d_out (d_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  fifo_word_t model_q[$];
  fifo_word_t model_dout;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic check_outputs(input string where);
    check({where, ".d_out"}, 32'(d_out), 32'(model_dout));
    check({where, ".empty"}, 32'(empty), 32'(model_q.size() == 0));
    check({where, ".full"},  32'(full),  32'(model_q.size() == DEPTH));
  endtask

  // One clock: apply inputs away from the edge, advance the model from its
  // pre-edge occupancy, then compare just after the edge.
  task automatic cycle(input logic w, input logic r, input fifo_word_t d, input string where);
    bit do_push;
    bit do_pop;
    @(negedge clk);
    write = w;
    read  = r;
    d_in  = d;
    do_push = w && (model_q.size() < DEPTH);
    do_pop  = r && (model_q.size() > 0);
    @(posedge clk);
    if (do_pop)  model_dout = model_q.pop_front();
    if (do_push) model_q.push_back(d);
    #1;
    write = 1'b0;
    read  = 1'b0;
    check_outputs(where);
  endtask

  initial begin
    write = 1'b0;
    read  = 1'b0;
    d_in  = '0;
    reset = 1'b0;
    model_dout = '0;

    repeat (3) @(posedge clk);
    #1;
    check_outputs("reset_hold");

    @(negedge clk);
    reset = 1'b1;
    cycle(1'b0, 1'b1, 16'd0, "read_empty");

    cycle(1'b1, 1'b0, 16'd100, "w100");
    cycle(1'b0, 1'b1, 16'd0,   "r100");
    cycle(1'b0, 1'b1, 16'd0,   "r_underflow");

    cycle(1'b1, 1'b0, 16'd103, "w103");
    cycle(1'b1, 1'b0, 16'd104, "w104");
    cycle(1'b1, 1'b1, 16'd105, "rw105");
    cycle(1'b0, 1'b1, 16'd0,   "r104");
    cycle(1'b0, 1'b1, 16'd0,   "r105");

    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, fifo_word_t'(106 + i), "fill");
    cycle(1'b1, 1'b0, 16'd122, "overflow");
    cycle(1'b1, 1'b1, 16'd123, "rw_full");
    cycle(1'b1, 1'b0, 16'd124, "refill");
    for (int i = 0; i < DEPTH + 1; i++) cycle(1'b0, 1'b1, 16'd0, "drain");

    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, fifo_word_t'(200 + i), "wrap_w10");
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 16'd0, "wrap_r10");
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, fifo_word_t'(300 + i), "wrap_w16");
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, 16'd0, "wrap_r16");

    // Randomized phases with varying push/pop bias to visit full and empty.
    for (int ph = 0; ph < 8; ph++) begin
      int wp;
      int rp;
      wp = (ph % 2 == 0) ? 80 : 30;
      rp = (ph % 2 == 0) ? 30 : 80;
      for (int i = 0; i < 60; i++) begin
        cycle(($urandom_range(99) < wp), ($urandom_range(99) < rp),
              fifo_word_t'($urandom), "rand");
      end
    end

    // Async reset mid-stream with five queued words and a nonzero d_out.
    while (model_q.size() > 0) cycle(1'b0, 1'b1, 16'd0, "pre_drain");
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, fifo_word_t'(400 + i), "pre_fill");
    cycle(1'b0, 1'b1, 16'd0, "pre_pop");
    check("pre_reset.d_out_nonzero", 32'(d_out != 0), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    model_q.delete();
    model_dout = '0;
    check_outputs("async_reset");
    check("async_reset.wr_ptr", 32'(dut.wr_ptr_q), 32'd0);
    check("async_reset.rd_ptr", 32'(dut.rd_ptr_q), 32'd0);
    #1;
    reset = 1'b1;
    cycle(1'b1, 1'b0, 16'd500, "post_w500");
    check("post_reset.wr_ptr", 32'(dut.wr_ptr_q), 32'd1);
    cycle(1'b1, 1'b0, 16'd501, "post_w501");
    cycle(1'b0, 1'b1, 16'd0,   "post_r500");
    cycle(1'b0, 1'b1, 16'd0,   "post_r501");
    cycle(1'b0, 1'b1, 16'd0,   "post_r_empty");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_fifo
